// File: rtl/mux32_pkg.sv
// Shared constants and types for the 32-channel round-robin collector.
package mux32_pkg;

  localparam int N_CH  = 32;
  localparam int SEL_W = 5;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_CH-1:0]  ch_vec_t;

endpackage

// File: rtl/rr_pick_32.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping 31->0. Returns the one-hot winner and its binary index.
module rr_pick_32
  import mux32_pkg::*;
(
  input  ch_vec_t req_i,
  input  sel_t    ptr_i,
  output ch_vec_t gnt_o,
  output sel_t    idx_o,
  output logic    any_o
);

  ch_vec_t rot;
  sel_t    first;

  // Rotate right so ptr lands on bit 0, then lowest set bit wins.
  assign rot = ch_vec_t'({req_i, req_i} >> ptr_i);

  always_comb begin
    first = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) first = sel_t'(i);
    end
  end

  assign any_o = |req_i;
  assign idx_o = first + ptr_i;
  assign gnt_o = any_o ? (ch_vec_t'(1) << idx_o) : '0;

endmodule

// File: rtl/rr_mux_32to1.sv
// 32-to-1 round-robin collector with a single-entry valid/ready output stage.
// Define RR_MUX_FIXED_PRIO_EN for lowest-index-wins priority (no ptr register).
module rr_mux_32to1
  import mux32_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [N_CH-1:0]        req_i,
  input  logic [N_CH*DATA_W-1:0] data_i,
  output logic [N_CH-1:0]        gnt_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [DATA_W-1:0]      data_o,
  output logic [SEL_W-1:0]       sel_o
);

  sel_t    ptr;
  ch_vec_t pick_gnt;
  sel_t    pick_idx;
  logic    pick_any;
  logic    cap;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  sel_t              sel_q, sel_d;

  rr_pick_32 u_pick (
    .req_i (req_i),
    .ptr_i (ptr),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // A grant is only issued when the stage is free or draining this cycle.
  assign cap   = ~rst_i & en_i & pick_any & (~valid_q | ready_i);
  assign gnt_o = cap ? pick_gnt : '0;

`ifdef RR_MUX_FIXED_PRIO_EN
  assign ptr = '0;
`else
  sel_t ptr_q, ptr_d;

  assign ptr   = ptr_q;
  assign ptr_d = cap ? pick_idx + sel_t'(1) : ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (cap) begin
      valid_d = 1'b1;
      data_d  = data_i[pick_idx*DATA_W +: DATA_W];
      sel_d   = pick_idx;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sel_o   = sel_q;

endmodule

// File: tb/tb_rr_mux_32to1.sv
// Scoreboard bench for rr_mux_32to1 (round-robin or RR_MUX_FIXED_PRIO_EN).
module tb_rr_mux_32to1;
  import mux32_pkg::*;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            en_i = 1'b0;
  logic            ready_i = 1'b0;
  logic [31:0]     req_i = '0;
  logic [32*DW-1:0] data_i;
  logic [31:0]     gnt_o;
  logic            valid_o;
  logic [DW-1:0]   data_o;
  logic [4:0]      sel_o;

  logic [DW-1:0] dat [32];

  int tests = 0;
  int fails = 0;
  logic [12:0] sbq[$];

  always #5 clk = ~clk;

  always_comb begin
    data_i = '0;
    for (int k = 0; k < 32; k++) data_i[k*DW +: DW] = dat[k];
  end

  rr_mux_32to1 #(.DATA_W(DW)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .en_i    (en_i),
    .req_i   (req_i),
    .data_i  (data_i),
    .gnt_o   (gnt_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .sel_o   (sel_o)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted item must match the oldest expected one.
  always @(negedge clk) begin
    logic [12:0] e;
    if (!rst_i && valid_o && ready_i) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got %h expected none",
                 {data_o, sel_o});
      end else begin
        e = sbq.pop_front();
        chk("sb_item", {19'd0, data_o, sel_o}, {19'd0, e});
      end
    end
  end

  task automatic cyc(input logic [31:0] req, input logic en,
                     input logic rdy, input int ch, input string nm);
    @(posedge clk);
    #1;
    req_i   = req;
    en_i    = en;
    ready_i = rdy;
    @(negedge clk);
    chk(nm, gnt_o, (ch < 0) ? 32'h0 : (32'h1 << ch));
    if (ch >= 0) sbq.push_back({dat[ch], 5'(ch)});
  endtask

  task automatic chk_out(input string nm, input logic v,
                         input logic [7:0] d, input logic [4:0] s);
    chk({nm, "_valid"}, {31'd0, valid_o}, {31'd0, v});
    chk({nm, "_data"}, {24'd0, data_o}, {24'd0, d});
    chk({nm, "_sel"}, {27'd0, sel_o}, {27'd0, s});
  endtask

  initial begin
    for (int k = 0; k < 32; k++) dat[k] = 8'(8'h10 + k);
    dat[7] = 8'hA5;
    rst_i   = 1'b1;
    en_i    = 1'b1;
    ready_i = 1'b1;
    req_i   = 32'hFFFF_FFFF;

    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", gnt_o, 32'h0);
      chk_out("rst", 1'b0, 8'h00, 5'd0);
    end

    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("first_gnt", gnt_o, 32'h1);
    sbq.push_back({dat[0], 5'd0});

    cyc(32'h0, 1'b1, 1'b1, -1, "idle0");
    cyc(32'h80, 1'b1, 1'b1, 7, "single7");
    cyc(32'h0, 1'b1, 1'b1, -1, "idle1");
    chk_out("single7_out", 1'b1, 8'hA5, 5'd7);

`ifndef RR_MUX_FIXED_PRIO_EN
    cyc(32'h4000_0000, 1'b1, 1'b1, 30, "gnt30");
    cyc(32'h8000_0008, 1'b1, 1'b1, 31, "wrap31");
    cyc(32'h0000_0008, 1'b1, 1'b1, 3, "wrap3");
    cyc(32'h0000_0018, 1'b1, 1'b1, 4, "ptr4");
`endif
    cyc(32'h0, 1'b1, 1'b1, -1, "drain");

    cyc(32'h4, 1'b1, 1'b0, 2, "bp_gnt2");
    cyc(32'h4, 1'b1, 1'b0, -1, "stall");
    chk_out("stall0", 1'b1, 8'h12, 5'd2);
    dat[2] = 8'h5C;
    for (int i = 1; i < 5; i++) begin
      cyc(32'h4, 1'b1, 1'b0, -1, "stall");
      chk_out("stall", 1'b1, 8'h12, 5'd2);
    end
    cyc(32'h4, 1'b1, 1'b1, 2, "bp_regnt2");
    cyc(32'h0, 1'b1, 1'b0, -1, "bp_hold");
    chk_out("bp_new", 1'b1, 8'h5C, 5'd2);

    cyc(32'hFFFF_FFFF, 1'b0, 1'b0, -1, "en0_hold");
    chk("en0_hold_v", {31'd0, valid_o}, 32'd1);
    cyc(32'hFFFF_FFFF, 1'b0, 1'b1, -1, "en0_drain");
    cyc(32'hFFFF_FFFF, 1'b0, 1'b1, -1, "en0_empty");
    chk("en0_empty_v", {31'd0, valid_o}, 32'd0);
    cyc(32'h0, 1'b1, 1'b1, -1, "noreq0");
    chk("noreq0_v", {31'd0, valid_o}, 32'd0);
    cyc(32'h0, 1'b1, 1'b1, -1, "noreq1");
    chk("noreq1_v", {31'd0, valid_o}, 32'd0);

`ifndef RR_MUX_FIXED_PRIO_EN
    cyc(32'hFFFF_FFFF, 1'b1, 1'b1, 3, "frozen_ptr");
    for (int i = 0; i < 34; i++) begin
      cyc(32'hFFFF_FFFF, 1'b1, 1'b1, (4 + i) % 32, "fair");
    end
`else
    cyc(32'hFFFF_FFFF, 1'b1, 1'b1, 0, "fixed_all");
    for (int i = 0; i < 8; i++) begin
      cyc(32'h0000_0220, 1'b1, 1'b1, 5, "fixed5");
    end
`endif
    cyc(32'h0, 1'b1, 1'b1, -1, "tail0");
    cyc(32'h0, 1'b1, 1'b1, -1, "tail1");
    chk("tail_v", {31'd0, valid_o}, 32'd0);
    chk("sb_empty", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
